// File: rtl/rv32_pkg.sv
// Shared request/response types for the data-memory responder.
// dmem_req_t : one captured memory request (store flag, byte address,
//              lane-aligned store data, byte enables).
// dmem_rsp_t : one response (full aligned load word, out-of-range flag).
package rv32_pkg;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } dmem_rsp_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Valid/ready request and response channels between a requester (master)
// and the data-memory responder (slave).
// Request : req_valid/req_ready handshake, req_we, req_addr, req_wdata, req_be.
// Response: rsp_valid/rsp_ready handshake, rsp_rdata, rsp_err.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Word-organised storage for the responder.
// clk   : clock
// addr  : word index
// we/be : byte-enabled write of wdata
// re    : load rdata register with the addressed word (synchronous read)
// rdata : registered read word; holds its value while re is low
// Contents are never reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [31:0]                    wdata,
  input  logic                           re,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency.
// clk    : clock, rising edge
// resetn : asynchronous active-low reset
// bus    : slave side of dmem_responder_if (request and response channels)
// A request is accepted in IDLE, waits LATENCY cycles in WAIT, then is
// committed to the array on the edge entering RESP; the response is held
// in RESP until the requester takes it.
module dmem_responder
  import rv32_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             resetn,
  dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e    state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  dmem_req_t req_q, req_d;
  dmem_req_t in_req, cur_req;
  dmem_rsp_t rsp;
  logic      accept, commit, cur_oor;
  logic [31:0] arr_rdata;

  function automatic logic out_of_range(input logic [31:0] addr);
    return addr[31:2] >= 30'(DEPTH_WORDS);
  endfunction

  always_comb begin
    in_req  = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata, be: bus.req_be};
    accept  = bus.req_valid && (state_q == IDLE);
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d = in_req;
          if (LATENCY == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // With zero latency the commit edge is the acceptance edge, so the
    // array must see the incoming request rather than the captured one.
    cur_req = (state_q == IDLE) ? in_req : req_q;
    cur_oor = out_of_range(cur_req.addr);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request payload is data only; it is qualified by the state register.
  always_ff @(posedge clk) begin
    req_q <= req_d;
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .addr  (cur_req.addr[AW+1:2]),
    .we    (commit && cur_req.we && !cur_oor),
    .be    (cur_req.be),
    .wdata (cur_req.wdata),
    .re    (commit && !cur_req.we && !cur_oor),
    .rdata (arr_rdata)
  );

  // Response fields are gated by the reset state register so they drop to
  // zero together with rsp_valid the moment resetn falls.
  always_comb begin
    rsp.err   = (state_q == RESP) && out_of_range(req_q.addr);
    rsp.rdata = ((state_q == RESP) && !req_q.we && !rsp.err) ? arr_rdata : 32'd0;
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp.rdata;
  assign bus.rsp_err   = rsp.err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) dut0 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus0.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic we, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be,
                     input logic [31:0] er, input logic ee);
    vec_t v;
    v.name = n; v.we = we; v.addr = a; v.wdata = d; v.be = be;
    v.exp_rdata = er; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  // One complete transaction on the LATENCY=2 instance with rsp_ready=1.
  task automatic run_txn(input vec_t v);
    int lat;
    bit rdy_seen;
    @(negedge clk);
    chk({v.name, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_we = v.we; bus.req_addr = v.addr;
    bus.req_wdata = v.wdata; bus.req_be = v.be; bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_we = 1'b1; bus.req_addr = 32'h10;
    bus.req_wdata = 32'hBAD0BAD0; bus.req_be = 4'hF;
    lat = 0; rdy_seen = 1'b0;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 20) begin
      if (bus.req_ready) rdy_seen = 1'b1;
      lat++;
      @(negedge clk);
    end
    chk({v.name, "_latency"}, 32'(lat), 32'd2);
    chk({v.name, "_ready_in_wait"}, {31'd0, rdy_seen}, 32'd0);
    chk({v.name, "_ready_in_resp"}, {31'd0, bus.req_ready}, 32'd0);
    chk({v.name, "_rdata"}, bus.rsp_rdata, v.exp_rdata);
    chk({v.name, "_err"}, {31'd0, bus.rsp_err}, {31'd0, v.exp_err});
    @(posedge clk);
    @(negedge clk);
    chk({v.name, "_valid_drop"}, {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!bus.rsp_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_rsp_seen"}, {31'd0, bus.rsp_valid}, 32'd1);
  endtask

  initial begin
    vec_t v;
    int cnt;
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.req_be = 0; bus.rsp_ready = 0;
    bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
    bus0.req_be = 0; bus0.rsp_ready = 0;

    add("st10",      1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        0);
    add("ld10",      0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 0);
    add("st12_b2",   1, 32'h12,       32'h00AB0000, 4'b0100, 32'h0,     0);
    add("ld13",      0, 32'h13,       32'h0,        4'h0, 32'hDEABBEEF, 0);
    add("st0",       1, 32'h0,        32'h01020304, 4'hF, 32'h0,        0);
    add("ld1000",    0, 32'h1000,     32'h0,        4'h0, 32'h0,        1);
    add("st1000",    1, 32'h1000,     32'hFFFFFFFF, 4'hF, 32'h0,        1);
    add("ld0_alias", 0, 32'h0,        32'h0,        4'h0, 32'h01020304, 0);
    add("ld_hi",     0, 32'h80000010, 32'h0,        4'h0, 32'h0,        1);
    add("st_last",   1, 32'hFFC,      32'h12345678, 4'hF, 32'h0,        0);
    add("ld_last",   0, 32'hFFF,      32'h0,        4'h0, 32'h12345678, 0);
    add("st10_be0",  1, 32'h10,       32'hFFFFFFFF, 4'h0, 32'h0,        0);
    add("ld10_b",    0, 32'h10,       32'h0,        4'h0, 32'hDEABBEEF, 0);
    add("st14",      1, 32'h14,       32'h00000000, 4'hF, 32'h0,        0);
    add("st14_b03",  1, 32'h14,       32'hAABBCCDD, 4'b1001, 32'h0,     0);
    add("ld14",      0, 32'h14,       32'h0,        4'h0, 32'hAA0000DD, 0);
    add("st20",      1, 32'h20,       32'h55AA55AA, 4'hF, 32'h0,        0);

    // Reset state
    #12;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata,          32'd0);
    @(negedge clk); resetn = 1'b1;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Stall in RESP with a competing request that must be ignored
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h10; bus.rsp_ready = 0;
    @(posedge clk); #1;
    bus.req_we = 1; bus.req_wdata = 32'h0; bus.req_be = 4'hF;
    @(negedge clk);
    wait_rsp("stall");
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("stall_rdata", bus.rsp_rdata, 32'hDEABBEEF);
      chk("stall_err",   {31'd0, bus.rsp_err}, 32'd0);
      chk("stall_ready", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1; bus.req_valid = 0;
    @(posedge clk); @(negedge clk);
    chk("stall_idle_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("stall_idle_valid", {31'd0, bus.rsp_valid}, 32'd0);
    v = vecs[12]; v.name = "ld10_after_stall";
    run_txn(v);

    // Reset while an error response is held
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h1000; bus.rsp_ready = 0;
    @(posedge clk); #1; bus.req_valid = 0;
    @(negedge clk);
    wait_rsp("rst_resp");
    chk("rst_resp_err_before", {31'd0, bus.rsp_err}, 32'd1);
    #2 resetn = 1'b0; #1;
    chk("rst_resp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_resp_err",   {31'd0, bus.rsp_err},   32'd0);
    chk("rst_resp_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk); resetn = 1'b1; bus.rsp_ready = 1;

    // Reset in the last WAIT cycle of a store: the store must not land
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 32'h20;
    bus.req_wdata = 32'h11111111; bus.req_be = 4'hF;
    @(posedge clk); #1; bus.req_valid = 0;
    @(posedge clk); #2 resetn = 1'b0; #1;
    chk("rst_wait_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_wait_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_wait_rdata", bus.rsp_rdata, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    add("ld20_after_rst", 0, 32'h20, 32'h0, 4'h0, 32'h55AA55AA, 0);
    run_txn(vecs[vecs.size()-1]);

    // LATENCY=0 instance: store then back-to-back loads
    @(negedge clk);
    bus0.req_valid = 1; bus0.req_we = 1; bus0.req_addr = 32'h8;
    bus0.req_wdata = 32'hCAFEF00D; bus0.req_be = 4'hF; bus0.rsp_ready = 1;
    @(posedge clk); #1;
    bus0.req_we = 0;
    @(negedge clk);
    chk("l0_st_valid", {31'd0, bus0.rsp_valid}, 32'd1);
    chk("l0_st_rdata", bus0.rsp_rdata, 32'd0);
    chk("l0_st_err",   {31'd0, bus0.rsp_err}, 32'd0);
    chk("l0_st_ready", {31'd0, bus0.req_ready}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus0.rsp_valid) begin
        cnt++;
        chk("l0_ld_rdata", bus0.rsp_rdata, 32'hCAFEF00D);
      end
    end
    chk("l0_ld_count", 32'(cnt), 32'd5);
    bus0.req_valid = 0;
    @(negedge clk);
    bus0.req_valid = 1; bus0.req_addr = 32'h40;
    @(posedge clk); #1; bus0.req_valid = 0;
    @(negedge clk);
    chk("l0_oor_valid", {31'd0, bus0.rsp_valid}, 32'd1);
    chk("l0_oor_err",   {31'd0, bus0.rsp_err},   32'd1);
    chk("l0_oor_rdata", bus0.rsp_rdata, 32'd0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
